// File: rtl/cpr_pkg.sv
// Shared CPR definitions: FSM state encoding and default 50 MHz timing constants.
// Used by both the prompter and the trainee-side monitor.
package cpr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPRESS = 2'd1,
    ST_BREATHE  = 2'd2,
    ST_ALARM    = 2'd3
  } cpr_state_e;

  localparam int CPR_DEBOUNCE_CYC   = 3;
  localparam int CPR_MIN_INT        = 25_000_000;
  localparam int CPR_MAX_INT        = 30_000_000;
  localparam int CPR_COMP_PER_SET   = 30;
  localparam int CPR_BREATH_PER_SET = 2;
  localparam int CPR_IDLE_TIMEOUT   = 100_000_000;

endpackage

// File: rtl/cpr_debounce.sv
// Two-flop synchroniser, stable-sample debouncer and rising-edge event pulse.
// The event pulse is registered together with the debounced level change.
module cpr_debounce #(
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_evt
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          r_s1, r_s2, r_level, r_evt;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive synchronised samples that differ from r_level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_evt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1  <= i_din;
      r_s2  <= r_s1;
      r_evt <= 1'b0;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        r_level <= r_s2;
        r_evt   <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/cpr_monitor.sv
// Trainee-side CPR monitor: classifies compression intervals, checks the
// compression/breath sequence, counts completed sets and flags inactivity.
module cpr_monitor
  import cpr_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = CPR_DEBOUNCE_CYC,
  parameter int MIN_INT        = CPR_MIN_INT,
  parameter int MAX_INT        = CPR_MAX_INT,
  parameter int COMP_PER_SET   = CPR_COMP_PER_SET,
  parameter int BREATH_PER_SET = CPR_BREATH_PER_SET,
  parameter int IDLE_TIMEOUT   = CPR_IDLE_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        compress_in,
  input  logic        breath_in,
  output logic        rate_ok,
  output logic        rate_fast,
  output logic        rate_slow,
  output logic        seq_err,
  output logic        alarm,
  output logic [31:0] interval,
  output logic [5:0]  comp_count,
  output logic [1:0]  breath_count,
  output logic [7:0]  set_count,
  output logic [1:0]  state_out
);

  localparam logic [5:0]  CPS  = 6'(COMP_PER_SET);
  localparam logic [1:0]  BPS  = 2'(BREATH_PER_SET);
  localparam logic [31:0] TMO  = 32'(IDLE_TIMEOUT);
  localparam logic [31:0] MINI = 32'(MIN_INT);
  localparam logic [31:0] MAXI = 32'(MAX_INT);

  logic w_cevt, w_bevt_raw, w_bevt;

  cpr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_comp (
    .clk(clk), .rst_n(rst_n), .i_din(compress_in), .o_evt(w_cevt)
  );
  cpr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_breath (
    .clk(clk), .rst_n(rst_n), .i_din(breath_in), .o_evt(w_bevt_raw)
  );

  // A compression in the same cycle as a breath wins; the breath is dropped.
  assign w_bevt = w_bevt_raw & ~w_cevt;

  cpr_state_e  r_state, w_state;
  logic [31:0] r_timer, w_timer, w_tinc;
  logic [31:0] r_interval, w_interval;
  logic [5:0]  r_comp, w_comp;
  logic [1:0]  r_breath, w_breath;
  logic [7:0]  r_set, w_set;
  logic        r_ok, r_fast, r_slow, r_seq, r_alarm;
  logic        w_ok, w_fast, w_slow, w_seq;

  // Timer was cleared on the previous event's edge, so timer+1 is the spacing.
  assign w_tinc = (&r_timer) ? r_timer : r_timer + 32'd1;

  always_comb begin
    w_state    = r_state;
    w_timer    = w_tinc;
    w_interval = r_interval;
    w_comp     = r_comp;
    w_breath   = r_breath;
    w_set      = r_set;
    w_ok       = 1'b0;
    w_fast     = 1'b0;
    w_slow     = 1'b0;
    w_seq      = 1'b0;
    if (!enable) begin
      w_state  = ST_IDLE;
      w_timer  = '0;
      w_comp   = '0;
      w_breath = '0;
      w_set    = '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_ALARM: begin
          if (w_cevt) begin
            w_state = ST_COMPRESS;
            w_comp  = 6'd1;
            w_timer = '0;
          end
        end
        ST_COMPRESS: begin
          if (w_cevt) begin
            w_timer    = '0;
            w_interval = w_tinc;
            w_fast     = (w_tinc < MINI);
            w_slow     = (w_tinc > MAXI);
            w_ok       = (w_tinc >= MINI) && (w_tinc <= MAXI);
            w_comp     = r_comp + 6'd1;
            if (r_comp + 6'd1 == CPS) begin
              w_state  = ST_BREATHE;
              w_breath = '0;
            end
          end else if (w_bevt) begin
            w_seq = 1'b1;
          end else if (r_timer == TMO) begin
            w_state = ST_ALARM;
            w_timer = '0;
          end
        end
        ST_BREATHE: begin
          if (w_cevt) begin
            w_seq    = 1'b1;
            w_state  = ST_COMPRESS;
            w_comp   = 6'd1;
            w_breath = '0;
            w_timer  = '0;
          end else if (w_bevt) begin
            w_timer = '0;
            if (r_breath + 2'd1 == BPS) begin
              w_state  = ST_COMPRESS;
              w_comp   = '0;
              w_breath = '0;
              w_set    = (r_set == 8'hFF) ? r_set : r_set + 8'd1;
            end else begin
              w_breath = r_breath + 2'd1;
            end
          end else if (r_timer == TMO) begin
            w_state = ST_ALARM;
            w_timer = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_interval <= '0;
      r_comp     <= '0;
      r_breath   <= '0;
      r_set      <= '0;
      r_ok       <= 1'b0;
      r_fast     <= 1'b0;
      r_slow     <= 1'b0;
      r_seq      <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_timer    <= w_timer;
      r_interval <= w_interval;
      r_comp     <= w_comp;
      r_breath   <= w_breath;
      r_set      <= w_set;
      r_ok       <= w_ok;
      r_fast     <= w_fast;
      r_slow     <= w_slow;
      r_seq      <= w_seq;
      r_alarm    <= (w_state == ST_ALARM);
    end
  end

  assign rate_ok      = r_ok;
  assign rate_fast    = r_fast;
  assign rate_slow    = r_slow;
  assign seq_err      = r_seq;
  assign alarm        = r_alarm;
  assign interval     = r_interval;
  assign comp_count   = r_comp;
  assign breath_count = r_breath;
  assign set_count    = r_set;
  assign state_out    = r_state;

endmodule

// File: tb/tb_cpr_monitor.sv
// Directed bench for cpr_monitor with small timing constants; every step
// drives on a falling edge and checks against hand-computed values.
module tb_cpr_monitor;

  logic        clk = 1'b0;
  logic        rst_n, enable, compress_in, breath_in;
  logic        rate_ok, rate_fast, rate_slow, seq_err, alarm;
  logic [31:0] interval;
  logic [5:0]  comp_count;
  logic [1:0]  breath_count;
  logic [7:0]  set_count;
  logic [1:0]  state_out;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpr_monitor #(
    .DEBOUNCE_CYC(3), .MIN_INT(20), .MAX_INT(30),
    .COMP_PER_SET(3), .BREATH_PER_SET(2), .IDLE_TIMEOUT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .compress_in(compress_in), .breath_in(breath_in),
    .rate_ok(rate_ok), .rate_fast(rate_fast), .rate_slow(rate_slow),
    .seq_err(seq_err), .alarm(alarm), .interval(interval),
    .comp_count(comp_count), .breath_count(breath_count),
    .set_count(set_count), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Rise g cycles after the previous rise (caller sits 6 cycles past it),
  // then return on the falling edge just after the event is consumed.
  task automatic comp_at(input int g);
    cyc(g - 6);
    compress_in = 1'b1;
    cyc(6);
    compress_in = 1'b0;
  endtask

  task automatic brth_at(input int g);
    cyc(g - 6);
    breath_in = 1'b1;
    cyc(6);
    breath_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; compress_in = 1'b0; breath_in = 1'b0;
    cyc(3);
    chk("rst_state", 32'(state_out), 0);
    chk("rst_comp", 32'(comp_count), 0);
    chk("rst_alarm", 32'(alarm), 0);
    chk("rst_interval", interval, 0);
    rst_n = 1'b1; enable = 1'b1;
    cyc(2);

    // 2-cycle glitch must not produce an event
    compress_in = 1'b1; cyc(2); compress_in = 1'b0; cyc(10);
    chk("glitch_state", 32'(state_out), 0);
    chk("glitch_comp", 32'(comp_count), 0);

    // latency: state changes on the 6th edge after the rise
    compress_in = 1'b1;
    cyc(5);
    chk("lat5_state", 32'(state_out), 0);
    cyc(1);
    chk("lat6_state", 32'(state_out), 1);
    chk("lat6_comp", 32'(comp_count), 1);
    chk("lat6_norate", 32'({rate_ok, rate_fast, rate_slow}), 0);
    cyc(4); compress_in = 1'b0;

    // spacing 25 -> ok
    comp_at(21);
    chk("r25_ok", 32'({rate_ok, rate_fast, rate_slow}), 32'b100);
    chk("r25_int", interval, 25);
    chk("r25_comp", 32'(comp_count), 2);
    cyc(1);
    chk("r25_pulse1", 32'(rate_ok), 0);

    // spacing 19 -> fast, third compression enters BREATHE
    comp_at(18);
    chk("r19_fast", 32'({rate_ok, rate_fast, rate_slow}), 32'b010);
    chk("r19_int", interval, 19);
    chk("r19_comp", 32'(comp_count), 3);
    chk("r19_state", 32'(state_out), 2);
    chk("r19_breath", 32'(breath_count), 0);

    // one breath, then a compression in BREATHE
    brth_at(20);
    chk("b1_breath", 32'(breath_count), 1);
    chk("b1_state", 32'(state_out), 2);
    comp_at(20);
    chk("seqB_err", 32'(seq_err), 1);
    chk("seqB_state", 32'(state_out), 1);
    chk("seqB_comp", 32'(comp_count), 1);
    chk("seqB_set", 32'(set_count), 0);
    chk("seqB_breath", 32'(breath_count), 0);
    chk("seqB_norate", 32'({rate_ok, rate_fast, rate_slow}), 0);

    // spacing 31 -> slow
    comp_at(31);
    chk("r31_slow", 32'({rate_ok, rate_fast, rate_slow}), 32'b001);
    chk("r31_int", interval, 31);
    chk("r31_comp", 32'(comp_count), 2);

    // breath during COMPRESS
    brth_at(20);
    chk("seqC_err", 32'(seq_err), 1);
    chk("seqC_breath", 32'(breath_count), 0);
    chk("seqC_state", 32'(state_out), 1);
    chk("seqC_comp", 32'(comp_count), 2);

    // finish the set: 3rd compression, two breaths
    comp_at(20);
    chk("set1_brstate", 32'(state_out), 2);
    chk("set1_comphold", 32'(comp_count), 3);
    brth_at(20);
    chk("set1_b1", 32'(breath_count), 1);
    brth_at(20);
    chk("set1_set", 32'(set_count), 1);
    chk("set1_state", 32'(state_out), 1);
    chk("set1_comp", 32'(comp_count), 0);

    // inclusive boundaries, then a full set at 25
    comp_at(20);
    chk("r20_ok", 32'({rate_ok, rate_fast, rate_slow}), 32'b100);
    chk("r20_int", interval, 20);
    chk("r20_comp", 32'(comp_count), 1);
    comp_at(30);
    chk("r30_ok", 32'({rate_ok, rate_fast, rate_slow}), 32'b100);
    chk("r30_int", interval, 30);
    comp_at(25);
    chk("set2_brstate", 32'(state_out), 2);
    brth_at(20);
    brth_at(20);
    chk("set2_set", 32'(set_count), 2);
    chk("set2_state", 32'(state_out), 1);

    // inactivity timeout in COMPRESS
    cyc(100);
    chk("tmo_pre_state", 32'(state_out), 1);
    chk("tmo_pre_alarm", 32'(alarm), 0);
    cyc(1);
    chk("tmo_state", 32'(state_out), 3);
    chk("tmo_alarm", 32'(alarm), 1);
    compress_in = 1'b1; cyc(6); compress_in = 1'b0;
    chk("alm_clr_state", 32'(state_out), 1);
    chk("alm_clr_alarm", 32'(alarm), 0);
    chk("alm_clr_comp", 32'(comp_count), 1);
    chk("alm_clr_norate", 32'({rate_ok, rate_fast, rate_slow}), 0);
    chk("alm_clr_int", interval, 25);

    // compression landing exactly when the timer hits the timeout
    comp_at(101);
    chk("race_state", 32'(state_out), 1);
    chk("race_alarm", 32'(alarm), 0);
    chk("race_slow", 32'({rate_ok, rate_fast, rate_slow}), 32'b001);
    chk("race_int", interval, 101);
    chk("race_comp", 32'(comp_count), 2);

    // async reset mid-BREATHE
    comp_at(25);
    brth_at(20);
    chk("pre_rst_state", 32'(state_out), 2);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_out), 0);
    chk("arst_comp", 32'(comp_count), 0);
    chk("arst_breath", 32'(breath_count), 0);
    chk("arst_set", 32'(set_count), 0);
    chk("arst_int", interval, 0);
    chk("arst_flags", 32'({rate_ok, rate_fast, rate_slow, seq_err, alarm}), 0);
    cyc(1);
    rst_n = 1'b1;

    // enable low in COMPRESS
    compress_in = 1'b1; cyc(6); compress_in = 1'b0;
    chk("en_start_state", 32'(state_out), 1);
    comp_at(25);
    chk("en_r25_int", interval, 25);
    chk("en_r25_comp", 32'(comp_count), 2);
    enable = 1'b0;
    cyc(1);
    chk("en_state", 32'(state_out), 0);
    chk("en_comp", 32'(comp_count), 0);
    chk("en_int_hold", interval, 25);
    chk("en_alarm", 32'(alarm), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
